// File: rtl/stat_poller.sv
// Statistics read poller: sweeps a flow range, reads each flow's counter with a response
// timeout, streams (flow, count) results and accumulates a per-sweep total.
module stat_poller #(
    parameter int unsigned A_WIDTH = 10,
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [A_WIDTH-1:0]         flow_first_i,
    input  logic [A_WIDTH-1:0]         flow_last_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       rd_stb_o,
    output logic [A_WIDTH-1:0]         rd_flow_num_o,
    input  logic [D_WIDTH-1:0]         rd_data_i,
    input  logic                       rd_data_val_i,
    output logic                       out_val_o,
    input  logic                       out_rdy_i,
    output logic [A_WIDTH-1:0]         out_flow_o,
    output logic [D_WIDTH-1:0]         out_data_o,
    output logic                       out_err_o,
    output logic [D_WIDTH+A_WIDTH-1:0] total_o,
    output logic [A_WIDTH:0]           timeouts_o
);

    localparam int unsigned T_WIDTH = $clog2(TIMEOUT + 1);
    localparam int unsigned TOT_W   = D_WIDTH + A_WIDTH;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StOut, StDone} state_e;

    state_e               state_q, state_d;
    logic [A_WIDTH-1:0]   cur_q, cur_d;
    logic [A_WIDTH-1:0]   last_q, last_d;
    logic [T_WIDTH-1:0]   timer_q, timer_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 rd_stb_q, rd_stb_d;
    logic [A_WIDTH-1:0]   rd_flow_num_q, rd_flow_num_d;
    logic                 out_val_q, out_val_d;
    logic [A_WIDTH-1:0]   out_flow_q, out_flow_d;
    logic [D_WIDTH-1:0]   out_data_q, out_data_d;
    logic                 out_err_q, out_err_d;
    logic [TOT_W-1:0]     total_q, total_d;
    logic [A_WIDTH:0]     timeouts_q, timeouts_d;

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        last_d        = last_q;
        timer_d       = timer_q;
        rd_flow_num_d = rd_flow_num_q;
        out_flow_d    = out_flow_q;
        out_data_d    = out_data_q;
        out_err_d     = out_err_q;
        total_d       = total_q;
        timeouts_d    = timeouts_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    total_d    = '0;
                    timeouts_d = '0;
                    if (flow_first_i <= flow_last_i) begin
                        cur_d   = flow_first_i;
                        last_d  = flow_last_i;
                        state_d = StReq;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StReq: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (rd_data_val_i) begin
                    out_flow_d = cur_q;
                    out_data_d = rd_data_i;
                    out_err_d  = 1'b0;
                    total_d    = total_q + TOT_W'(rd_data_i);
                    state_d    = StOut;
                end else if (timer_q == T_WIDTH'(TIMEOUT - 1)) begin
                    // This idle cycle is the TIMEOUT-th one without a response.
                    out_flow_d = cur_q;
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                    timeouts_d = timeouts_q + 1'b1;
                    state_d    = StOut;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StOut: begin
                if (out_rdy_i) begin
                    // Compare before increment so the top flow number never wraps.
                    if (cur_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered, decoded from the next state.
        busy_d    = (state_d == StReq) || (state_d == StWait) || (state_d == StOut);
        done_d    = (state_d == StDone);
        rd_stb_d  = (state_d == StReq);
        out_val_d = (state_d == StOut);
        if (state_d == StReq) begin
            rd_flow_num_d = cur_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            cur_q         <= '0;
            last_q        <= '0;
            timer_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_stb_q      <= 1'b0;
            rd_flow_num_q <= '0;
            out_val_q     <= 1'b0;
            out_flow_q    <= '0;
            out_data_q    <= '0;
            out_err_q     <= 1'b0;
            total_q       <= '0;
            timeouts_q    <= '0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            last_q        <= last_d;
            timer_q       <= timer_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rd_stb_q      <= rd_stb_d;
            rd_flow_num_q <= rd_flow_num_d;
            out_val_q     <= out_val_d;
            out_flow_q    <= out_flow_d;
            out_data_q    <= out_data_d;
            out_err_q     <= out_err_d;
            total_q       <= total_d;
            timeouts_q    <= timeouts_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign rd_stb_o      = rd_stb_q;
    assign rd_flow_num_o = rd_flow_num_q;
    assign out_val_o     = out_val_q;
    assign out_flow_o    = out_flow_q;
    assign out_data_o    = out_data_q;
    assign out_err_o     = out_err_q;
    assign total_o       = total_q;
    assign timeouts_o    = timeouts_q;

endmodule
